jtframe_msg_render: RTL and testbench

- Pixel renderer directly downstream of the on-screen message character memory.
- Generates the character-memory scan address from the video counters and latches the returned character code and attribute.
- Fetches one font row from an external font ROM, then shifts it out one pixel per pxl_cen.
- Output feeds the frame's video mixer / OSD overlay as a per-pixel "message pixel" plus colour.

---
 rtl/jtframe_msg_pkg.sv | 15 +
 rtl/jtframe_msg_shifter.sv | 64 ++++++
 rtl/jtframe_msg_render.sv | 97 +++++++++
 tb/tb_jtframe_msg_render.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_msg_pkg.sv
// Shared constants for the on-screen message renderer: tile phases and tile width.
// Latency: none (constants only).
// Backpressure: none; every stage in the renderer advances only on pxl_cen.
package jtframe_msg_pkg;

   localparam int TILE_W = 8;

   // Tile phase (hdump[2:0]) at which each fetch stage captures its inputs
   localparam logic [2:0] PH_SCAN = 3'd0;
   localparam logic [2:0] PH_CODE = 3'd1;
   localparam logic [2:0] PH_FONT = 3'd2;
   localparam logic [2:0] PH_ROW  = 3'd3;
   localparam logic [2:0] PH_LOAD = 3'd7;

endpackage

// File: rtl/jtframe_msg_shifter.sv
// Glyph row shifter: loads a font row at PH_LOAD, shifts MSB-first, gates with enable/blank.
// Latency: one pxl_cen from shift-register MSB to registered msg_pxl/msg_pal.
// Backpressure: none; holds all state while pxl_cen is low. Optional JTFRAME_MSG_SHADOW_EN adds msg_shadow.
module jtframe_msg_shifter
   import jtframe_msg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pxl_cen,
   input  logic [2:0]        ph,
   input  logic [TILE_W-1:0] row,
   input  logic [3:0]        pal,
   input  logic              enable,
   input  logic              blank,
`ifdef JTFRAME_MSG_SHADOW_EN
   output logic              msg_shadow,
`endif
   output logic              msg_pxl,
   output logic [3:0]        msg_pal
);

   logic [TILE_W-1:0] sh;
   logic [3:0]        shpal;
   logic              show;
   logic              bit_now;

   assign show    = enable & ~blank;
   assign bit_now = sh[TILE_W-1];

   // Load the next tile's row on its last phase so pixel 0 is emitted at phase 0; otherwise shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh      <= '0;
         shpal   <= '0;
         msg_pxl <= 1'b0;
         msg_pal <= '0;
      end else if (pxl_cen) begin
         if (ph == PH_LOAD) begin
            sh    <= row;
            shpal <= pal;
         end else begin
            sh <= {sh[TILE_W-2:0], 1'b0};
         end
         msg_pxl <= bit_now & show;
         msg_pal <= (bit_now & show) ? shpal : 4'd0;
      end
   end

`ifdef JTFRAME_MSG_SHADOW_EN
   logic prev_bit;

   // Drop shadow one pixel right of a lit pixel; prev_bit follows the stream across tile boundaries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_bit   <= 1'b0;
         msg_shadow <= 1'b0;
      end else if (pxl_cen) begin
         prev_bit   <= bit_now;
         msg_shadow <= ~bit_now & prev_bit & show;
      end
   end
`endif

endmodule

// File: rtl/jtframe_msg_render.sv
// Message renderer: scans character memory, fetches a font row, and streams message pixels.
// Latency: a tile's pixels appear 8 pxl_cen after its scan address is issued (one tile ahead).
// Backpressure: none; all state holds while pxl_cen is low. Optional JTFRAME_MSG_SHADOW_EN adds msg_shadow.
module jtframe_msg_render
   import jtframe_msg_pkg::*;
#(
   parameter int SW    = 10,
   parameter int FONTW = 10
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             pxl_cen,
   input  logic [8:0]       hdump,
   input  logic [8:0]       vdump,
   input  logic             blank,
   input  logic             enable,
   output logic [SW-1:0]    scan,
   input  logic [7:0]       msg_low,
   input  logic [7:0]       msg_high,
   output logic [FONTW-1:0] font_addr,
   input  logic [7:0]       font_data,
`ifdef JTFRAME_MSG_SHADOW_EN
   output logic             msg_shadow,
`endif
   output logic             msg_pxl,
   output logic [3:0]       msg_pal
);

   localparam int HW = SW / 2;

   logic [2:0]         ph;
   logic [HW-1:0]      col_next;
   logic [FONTW-4:0]   code_l;
   logic [3:0]         pal_l;
   logic [TILE_W-1:0]  row_l;
   // Stage-valid chain: a stage only captures once its predecessor has, so a
   // partial sequence after reset cannot push a bogus font row into the shifter
   logic               vld_scan;
   logic               vld_code;
   logic               vld_font;
   logic               unused_bits;

   assign ph          = hdump[2:0];
   assign col_next    = hdump[3 +: HW] + HW'(1);
   assign unused_bits = ^{hdump, vdump, msg_low, msg_high};

   // Fetch pipeline: each stage samples only at its own tile phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan      <= '0;
         code_l    <= '0;
         pal_l     <= '0;
         font_addr <= '0;
         row_l     <= '0;
         vld_scan  <= 1'b0;
         vld_code  <= 1'b0;
         vld_font  <= 1'b0;
      end else if (pxl_cen) begin
         case (ph)
            PH_SCAN: begin
               scan     <= SW'({vdump[3 +: HW], col_next});
               vld_scan <= 1'b1;
            end
            PH_CODE: if (vld_scan) begin
               code_l   <= msg_low[FONTW-4:0];
               pal_l    <= msg_high[3:0];
               vld_code <= 1'b1;
            end
            PH_FONT: if (vld_code) begin
               font_addr <= {code_l, vdump[2:0]};
               vld_font  <= 1'b1;
            end
            PH_ROW: if (vld_font) begin
               row_l <= font_data;
            end
            default: ;
         endcase
      end
   end

   jtframe_msg_shifter u_shifter (
      .clk        (clk),
      .rst        (rst),
      .pxl_cen    (pxl_cen),
      .ph         (ph),
      .row        (row_l),
      .pal        (pal_l),
      .enable     (enable),
      .blank      (blank),
`ifdef JTFRAME_MSG_SHADOW_EN
      .msg_shadow (msg_shadow),
`endif
      .msg_pxl    (msg_pxl),
      .msg_pal    (msg_pal)
   );

endmodule

// File: tb/tb_jtframe_msg_render.sv
// Bench for jtframe_msg_render: table vectors, hand sequences and a randomized run vs. a memory-level model.
// Latency: pixels of column c are expected during tile c, fetched one tile earlier.
// Backpressure: pxl_cen stalls must hold every output.
module tb_jtframe_msg_render;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pxl_cen = 1'b0;
   logic [8:0] hdump = '0;
   logic [8:0] vdump = '0;
   logic       blank = 1'b0;
   logic       enable = 1'b1;
   logic [9:0] scan;
   logic [7:0] msg_low, msg_high;
   logic [9:0] font_addr;
   logic [7:0] font_data;
   logic       msg_pxl;
   logic [3:0] msg_pal;
`ifdef JTFRAME_MSG_SHADOW_EN
   logic       msg_shadow;
`endif

   logic [7:0] cmem_low  [1024];
   logic [7:0] cmem_high [1024];
   logic [7:0] font_mem  [1024];

   assign msg_low   = cmem_low[scan];
   assign msg_high  = cmem_high[scan];
   assign font_data = font_mem[font_addr];

   always #5 clk = ~clk;

   jtframe_msg_render #(.SW(10), .FONTW(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .pxl_cen    (pxl_cen),
      .hdump      (hdump),
      .vdump      (vdump),
      .blank      (blank),
      .enable     (enable),
      .scan       (scan),
      .msg_low    (msg_low),
      .msg_high   (msg_high),
      .font_addr  (font_addr),
      .font_data  (font_data),
`ifdef JTFRAME_MSG_SHADOW_EN
      .msg_shadow (msg_shadow),
`endif
      .msg_pxl    (msg_pxl),
      .msg_pal    (msg_pal)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the pixel shown at hdump h comes straight from the memories
   function automatic logic [7:0] m_row(input logic [4:0] col, input logic [8:0] v);
      logic [9:0] a;
      logic [7:0] c;
      a = {v[7:3], col};
      c = cmem_low[a];
      return font_mem[{c[6:0], v[2:0]}];
   endfunction

   function automatic logic [3:0] m_palf(input logic [4:0] col, input logic [8:0] v);
      logic [9:0] a;
      logic [7:0] at;
      a  = {v[7:3], col};
      at = cmem_high[a];
      return at[3:0];
   endfunction

   logic       m_pxl = 1'b0;
   logic [3:0] m_pal = '0;
   logic       m_sh = 1'b0;
   logic       m_prev = 1'b0;

   // One active pixel: drive inputs, take a pxl_cen edge, update the model
   task automatic pix(input logic [8:0] h, input logic bl, input logic en);
      logic [7:0] r;
      logic       b, show;
      hdump = h; blank = bl; enable = en; pxl_cen = 1'b1;
      tick();
      r      = m_row(h[7:3], vdump);
      b      = r[3'd7 - h[2:0]];
      show   = en & ~bl;
      m_sh   = ~b & m_prev & show;
      m_prev = b;
      m_pxl  = b & show;
      m_pal  = m_pxl ? m_palf(h[7:3], vdump) : 4'd0;
   endtask

   typedef struct {
      logic [7:0] code;
      logic [7:0] attr;
      logic [2:0] line;
      logic [7:0] row;
      logic       bl_a;
      logic       bl_b;
      logic       en;
      logic [7:0] exp_pxl;
      logic [3:0] exp_pal;
      logic [9:0] exp_fa;
   } vec_t;

   localparam int NV = 7;
   vec_t       vt [NV];
   vec_t       v;
   logic [6:0] code7;
   logic       bit_e;
   logic [9:0] a;
   logic [7:0] sh_row [2];
   int         sh_at  [2];
   logic       bl_t;
   logic [7:0] pat;

   initial begin
      // code, attr, line, row, blank(fetch tile), blank(show tile), en, exp pixels, exp pal, exp font_addr
      vt[0] = '{8'h41, 8'h05, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 4'h5, 10'h20B};
      vt[1] = '{8'h41, 8'h05, 3'd3, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h00, 4'h5, 10'h20B};
      vt[2] = '{8'h41, 8'h05, 3'd3, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 4'h5, 10'h20B};
      vt[3] = '{8'h41, 8'h05, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 4'h5, 10'h20B};
      vt[4] = '{8'h7F, 8'hFC, 3'd7, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 4'hC, 10'h3FF};
      vt[5] = '{8'h80, 8'h3A, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 4'hA, 10'h000};
      vt[6] = '{8'h12, 8'h01, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 4'h1, 10'h095};

      for (int i = 0; i < 1024; i++) begin
         cmem_low[i] = '0; cmem_high[i] = '0; font_mem[i] = '0;
      end

      // Reset state
      tick(); tick();
      chk("rst_scan", 32'(scan), 32'd0);
      chk("rst_font_addr", 32'(font_addr), 32'd0);
      chk("rst_pxl", 32'(msg_pxl), 32'd0);
      chk("rst_pal", 32'(msg_pal), 32'd0);
      rst = 1'b0;

      // Scan address generation, including column wrap
      vdump = 9'h010;
      pix(9'h0F8, 1'b0, 1'b1);
      chk("scan_wrap", 32'(scan), 32'h040);
      pix(9'h008, 1'b0, 1'b1);
      chk("scan_col2", 32'(scan), 32'h042);

      // Table vectors: glyph at column 1 of tile row 4, shown during hdump 8..15
      for (int i = 0; i < NV; i++) begin
         v     = vt[i];
         vdump = {1'b0, 5'd4, v.line};
         cmem_low[10'h081]  = v.code;
         cmem_high[10'h081] = v.attr;
         code7 = v.code[6:0];
         font_mem[{code7, v.line}] = v.row;
         for (int h = 0; h < 16; h++) begin
            pix(9'(h), (h < 8) ? v.bl_a : v.bl_b, v.en);
            if (h == 0) chk("tbl_scan", 32'(scan), 32'h081);
            if (h == 2) chk("tbl_font_addr", 32'(font_addr), 32'(v.exp_fa));
            if (h >= 8) begin
               bit_e = v.exp_pxl[15 - h];
               chk("tbl_pxl", 32'(msg_pxl), 32'(bit_e));
               chk("tbl_pal", 32'(msg_pal), bit_e ? 32'(v.exp_pal) : 32'd0);
            end
         end
      end

      // pxl_cen stall mid-tile: glyph 0xA5, stall after pixel 2 (lit, pal 5)
      vdump = {1'b0, 5'd4, 3'd3};
      cmem_low[10'h081] = 8'h41; cmem_high[10'h081] = 8'h05;
      font_mem[10'h20B] = 8'hA5;
      pat = 8'hA5;
      for (int h = 0; h < 11; h++) begin
         pix(9'(h), 1'b0, 1'b1);
         if (h >= 8) chk("stall_pre", 32'(msg_pxl), 32'(pat[15 - h]));
      end
      for (int k = 0; k < 5; k++) begin
         pxl_cen = 1'b0; blank = 1'b1; enable = 1'b0;
         tick();
         chk("stall_pxl", 32'(msg_pxl), 32'd1);
         chk("stall_pal", 32'(msg_pal), 32'd5);
      end
      for (int h = 11; h < 16; h++) begin
         pix(9'(h), 1'b0, 1'b1);
         chk("stall_post", 32'(msg_pxl), 32'(pat[15 - h]));
      end

`ifdef JTFRAME_MSG_SHADOW_EN
      // Drop shadow inside a tile and across the tile boundary
      sh_row[0] = 8'h80; sh_at[0] = 9;
      sh_row[1] = 8'h01; sh_at[1] = 16;
      for (int c = 0; c < 2; c++) begin
         cmem_low[10'h081] = 8'h50; cmem_low[10'h082] = 8'h51;
         a = {7'h50, 3'd3}; font_mem[a] = sh_row[c];
         a = {7'h51, 3'd3}; font_mem[a] = 8'h00;
         for (int h = 0; h < 24; h++) begin
            pix(9'(h), 1'b0, 1'b1);
            if (h >= 9) chk("shadow", 32'(msg_shadow), 32'(h == sh_at[c]));
         end
      end
`endif

      // Randomized lines against the memory-level model, with random stalls
      for (int i = 0; i < 1024; i++) begin
         cmem_low[i]  = 8'($urandom);
         cmem_high[i] = 8'($urandom);
         font_mem[i]  = 8'($urandom);
      end
      bl_t = 1'b0;
      for (int ln = 0; ln < 4; ln++) begin
         vdump = 9'($urandom_range(0, 255));
         for (int h = 0; h < 256; h++) begin
            if (h % 8 == 0) bl_t = ($urandom_range(0, 3) == 0);
            pix(9'(h), bl_t, $urandom_range(0, 7) != 0);
            if (h >= 8) begin
               chk("rnd_pxl", 32'(msg_pxl), 32'(m_pxl));
               chk("rnd_pal", 32'(msg_pal), 32'(m_pal));
            end
`ifdef JTFRAME_MSG_SHADOW_EN
            if (h >= 9) chk("rnd_shadow", 32'(msg_shadow), 32'(m_sh));
`endif
            if ($urandom_range(0, 5) == 0) begin
               for (int k = 0; k < 3; k++) begin
                  pxl_cen = 1'b0;
                  blank   = 1'($urandom);
                  enable  = 1'($urandom);
                  tick();
                  if (h >= 8) chk("rnd_hold", 32'(msg_pxl), 32'(m_pxl));
               end
            end
         end
      end

      // Mid-line reset: partial sequence must not reach the screen
      vdump = {1'b0, 5'd4, 3'd3};
      for (int c = 0; c < 32; c++) begin
         cmem_low[{5'd4, 5'(c)}] = 8'h00; cmem_high[{5'd4, 5'(c)}] = 8'h03;
      end
      font_mem[10'h003] = 8'hFF;
      cmem_low[10'h082] = 8'h41; cmem_high[10'h082] = 8'h05;
      font_mem[10'h20B] = 8'hA5;
      for (int h = 0; h < 5; h++) pix(9'(h), 1'b0, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_scan", 32'(scan), 32'd0);
      chk("arst_font_addr", 32'(font_addr), 32'd0);
      chk("arst_pxl", 32'(msg_pxl), 32'd0);
      chk("arst_pal", 32'(msg_pal), 32'd0);
      tick(); tick();
      rst = 1'b0;
      for (int h = 2; h < 8; h++) begin
         pix(9'(h), 1'b0, 1'b1);
         chk("rel_pxl", 32'(msg_pxl), 32'd0);
         chk("rel_scan", 32'(scan), 32'd0);
         chk("rel_font_addr", 32'(font_addr), 32'd0);
      end
      for (int h = 8; h < 16; h++) begin
         pix(9'(h), 1'b0, 1'b1);
         chk("rel_first_tile", 32'(msg_pxl), 32'd0);
      end
      for (int h = 16; h < 24; h++) begin
         pix(9'(h), 1'b0, 1'b1);
         chk("rel_valid_pxl", 32'(msg_pxl), 32'(m_pxl));
         chk("rel_valid_pal", 32'(msg_pal), 32'(m_pal));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
